microwave_timer: RTL and testbench

Countdown timer stage that sits directly upstream of the magnetron controller and produces its `timer_done` input. It takes BCD digits from the keypad, holds an MM:SS cook time, and decrements it once per second while the magnetron is on. It asserts `timer_done` whenever the held time is 00:00, which blocks or terminates cooking.

---
 rtl/microwave_timer_pkg.sv | 13 +
 rtl/microwave_timer_bcd_digit_dec.sv | 50 +++++
 rtl/microwave_timer.sv | 118 +++++++++++
 tb/tb_microwave_timer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/microwave_timer_pkg.sv
// Shared constants for the microwave countdown timer.
//   BCD_W                 - width of one BCD digit
//   TICKS_PER_SEC_DEFAULT - clock cycles per second at the nominal 50 MHz clock
//   BCD_MAX               - largest legal BCD digit
//   SEC_TENS_WRAP         - value the seconds-tens digit takes on a borrow
package microwave_timer_pkg;

    localparam int unsigned BCD_W                 = 4;
    localparam int unsigned TICKS_PER_SEC_DEFAULT = 50_000_000;
    localparam int unsigned BCD_MAX               = 9;
    localparam int unsigned SEC_TENS_WRAP         = 5;

endpackage

// File: rtl/microwave_timer_bcd_digit_dec.sv
// One BCD digit register with clear, shift-in and borrow-driven decrement.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   clr          - synchronous clear to 0
//   shift        - load shift_in (keypad shift)
//   shift_in     - digit shifted in from the lower neighbour / keypad
//   borrow_in    - decrement request from the lower digit (or the prescaler)
//   digit        - current digit value
//   borrow_out   - borrow passed upward: borrow_in while this digit is 0
// Priority: rst > clr > shift > borrow_in.
module bcd_digit_dec
    import microwave_timer_pkg::*;
#(
    parameter int unsigned WRAP = BCD_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic [BCD_W-1:0] shift_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit,
    output logic             borrow_out
);

    logic [BCD_W-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (shift) begin
            digit_d = shift_in;
        end else if (borrow_in) begin
            digit_d = (digit_q == '0) ? BCD_W'(WRAP) : digit_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in && (digit_q == '0);

endmodule

// File: rtl/microwave_timer.sv
// MM:SS countdown timer feeding timer_done to the magnetron controller.
// Keypad digits shift in from the right while idle; while enabled and nonzero
// the time decrements once every TICKS_PER_SEC cycles.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   clearn          - active-low synchronous clear (beats digit entry and counting)
//   digit_valid     - strobe qualifying digit_in
//   digit_in        - BCD keypad digit; values above 9 are ignored
//   enable          - count enable (magnetron on); also blocks digit entry
//   min_tens .. sec_ones - registered BCD time
//   timer_done      - time is 00:00 (combinational decode of the digits)
//   sec_tick        - one-cycle pulse coincident with each decrement
module microwave_timer
    import microwave_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clearn,
    input  logic             digit_valid,
    input  logic [BCD_W-1:0] digit_in,
    input  logic             enable,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             timer_done,
    output logic             sec_tick
);

    localparam int unsigned PreW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic            sec_tick_q, sec_tick_d;

    logic clr, shift, run, tick;
    logic so_borrow, st_borrow, mo_borrow, unused_min_tens_borrow;

    assign timer_done = (min_tens == '0) && (min_ones == '0) &&
                        (sec_tens == '0) && (sec_ones == '0);

    assign clr   = !clearn;
    assign shift = !clr && digit_valid && !enable && (digit_in <= BCD_W'(BCD_MAX));
    // enable excludes shift, so only clear has to be masked here.
    assign run   = !clr && enable && !timer_done;
    assign tick  = run && (pre_q == PreMax);

    always_comb begin
        pre_d      = pre_q;
        sec_tick_d = tick;
        if (clr || shift) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign sec_tick = sec_tick_q;

    // The prescaler tick is the borrow into the seconds-ones digit; borrows ripple upward.
    bcd_digit_dec #(.WRAP(BCD_MAX)) u_sec_ones (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .shift      (shift),
        .shift_in   (digit_in),
        .borrow_in  (tick),
        .digit      (sec_ones),
        .borrow_out (so_borrow)
    );

    bcd_digit_dec #(.WRAP(SEC_TENS_WRAP)) u_sec_tens (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .shift      (shift),
        .shift_in   (sec_ones),
        .borrow_in  (so_borrow),
        .digit      (sec_tens),
        .borrow_out (st_borrow)
    );

    bcd_digit_dec #(.WRAP(BCD_MAX)) u_min_ones (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .shift      (shift),
        .shift_in   (sec_tens),
        .borrow_in  (st_borrow),
        .digit      (min_ones),
        .borrow_out (mo_borrow)
    );

    // Never borrows out: 00:00 is never decremented.
    bcd_digit_dec #(.WRAP(BCD_MAX)) u_min_tens (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .shift      (shift),
        .shift_in   (min_ones),
        .borrow_in  (mo_borrow),
        .digit      (min_tens),
        .borrow_out (unused_min_tens_borrow)
    );

endmodule

// File: tb/tb_microwave_timer.sv
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clearn = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       enable = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, sec_tick;

    int checks = 0;
    int failures = 0;
    int ticks;

    microwave_timer #(.TICKS_PER_SEC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .clearn      (clearn),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .enable      (enable),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .timer_done  (timer_done),
        .sec_tick    (sec_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cur_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n edges; sample and drive 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n edges and count sec_tick pulses seen after each edge.
    task automatic run_edges(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step(1);
            if (sec_tick) cnt++;
        end
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        step(1);
        digit_valid = 1'b0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    initial begin
        // 1. Reset
        step(2);
        rst = 1'b0;
        check("reset_time", cur_time(), 16'h0000);
        check("reset_done", 16'(timer_done), 16'd1);
        check("reset_tick", 16'(sec_tick), 16'd0);

        // 2. Entry
        key(4'd1); key(4'd3); key(4'd0);
        check("entry_time", cur_time(), 16'h0130);
        check("entry_done", 16'(timer_done), 16'd0);
        key(4'hA);
        check("entry_bad_digit", cur_time(), 16'h0130);
        enable = 1'b1;
        key(4'd5);
        enable = 1'b0;
        check("entry_while_enabled", cur_time(), 16'h0130);
        // Oldest digit falls off the left.
        clear();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        check("entry_shift_out", cur_time(), 16'h2345);
        // Clear beats a simultaneous strobe.
        clearn = 1'b0;
        key(4'd7);
        clearn = 1'b1;
        check("clear_beats_digit", cur_time(), 16'h0000);

        // 3. Countdown
        key(4'd2);
        enable = 1'b1;
        run_edges(3, ticks);
        check("cd_before_first", cur_time(), 16'h0002);
        check("cd_no_early_tick", 16'(ticks), 16'd0);
        run_edges(1, ticks);
        check("cd_first", cur_time(), 16'h0001);
        check("cd_first_tick", 16'(ticks), 16'd1);
        run_edges(4, ticks);
        check("cd_zero", cur_time(), 16'h0000);
        check("cd_zero_done", 16'(timer_done), 16'd1);
        check("cd_final_tick", 16'(sec_tick), 16'd1);
        run_edges(10, ticks);
        check("cd_hold_zero", cur_time(), 16'h0000);
        check("cd_no_tick_at_zero", 16'(ticks), 16'd0);
        enable = 1'b0;

        // 4. Borrow chain
        clear();
        key(4'd1); key(4'd0); key(4'd0);
        enable = 1'b1;
        run_edges(4, ticks);
        enable = 1'b0;
        check("borrow_0100", cur_time(), 16'h0059);
        clear();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        enable = 1'b1;
        run_edges(4, ticks);
        enable = 1'b0;
        check("borrow_1000", cur_time(), 16'h0959);

        // 5. Pause resumes the partial second
        clear();
        key(4'd5);
        enable = 1'b1;
        run_edges(2, ticks);
        enable = 1'b0;
        run_edges(10, ticks);
        check("pause_hold", cur_time(), 16'h0005);
        enable = 1'b1;
        run_edges(1, ticks);
        check("pause_third", cur_time(), 16'h0005);
        run_edges(1, ticks);
        check("pause_fourth", cur_time(), 16'h0004);
        enable = 1'b0;
        // Oversized seconds
        clear();
        key(4'd9); key(4'd0);
        enable = 1'b1;
        run_edges(4, ticks);
        enable = 1'b0;
        check("oversize_90", cur_time(), 16'h0089);

        // 6. Clear mid-run
        clear();
        key(4'd2); key(4'd0); key(4'd0);
        enable = 1'b1;
        run_edges(2, ticks);
        clearn = 1'b0;
        step(1);
        check("midrun_clear", cur_time(), 16'h0000);
        check("midrun_clear_done", 16'(timer_done), 16'd1);
        clearn = 1'b1;
        enable = 1'b0;
        key(4'd1);
        enable = 1'b1;
        run_edges(3, ticks);
        check("reentry_3_edges", cur_time(), 16'h0001);
        run_edges(1, ticks);
        check("reentry_4_edges", cur_time(), 16'h0000);
        check("reentry_tick", 16'(ticks), 16'd1);
        enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
